// File: rtl/adc_trigger_gate.sv
// Trigger/pre-trigger gate: ring-buffer delay line between the ADC packer
// and the DDR3 write FIFO, passing only a triggered capture window.
module adc_trigger_gate #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              arm,
  input  logic              abort,
  input  logic [1:0]        trig_mode,
  input  logic              trig_src,
  input  logic [7:0]        trig_level,
  input  logic [ADDR_W-1:0] pre_num,
  input  logic [31:0]       total_num,
  input  logic              force_trig,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              out_full,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              armed,
  output logic              triggered,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WAIT_TRIG,
    CAPTURE
  } state_t;

  state_t state, state_d;

  logic [1:0]        mode_q;
  logic              src_q;
  logic [7:0]        lvl_q;
  logic [ADDR_W-1:0] pre_q;
  logic [31:0]       total_q;

  logic [ADDR_W-1:0] wptr, raddr, fill_cnt, fill_d, fill_nx;
  logic [31:0]       cnt, cnt_d, cnt_nx;
  logic [7:0]        prev_b, b;
  logic              prev_ok;
  logic              restart, proc, emit, done_d;
  logic              rise, fall, hit, trig;
  logic [DATA_W-1:0] rdata;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  assign restart = arm & ~abort;
  assign proc    = din_valid & (state != IDLE) & ~arm & ~abort;
  assign raddr   = wptr - pre_q;
  // pre_q==0 means read and write hit the same slot, so bypass the RAM
  assign rdata   = (pre_q == '0) ? din : mem[raddr];
  assign fill_nx = fill_cnt + ADDR_W'(1);
  assign cnt_nx  = cnt + 32'd1;

  assign b    = src_q ? din[15:8] : din[7:0];
  assign rise = prev_ok & (prev_b < lvl_q) & (b >= lvl_q);
  assign fall = prev_ok & (prev_b >= lvl_q) & (b < lvl_q);

  always_comb begin
    hit = 1'b0;
    case (mode_q)
      2'd0: hit = 1'b1;
      2'd1: hit = rise;
      2'd2: hit = fall;
      2'd3: hit = rise | fall;
      default: hit = 1'b0;
    endcase
  end

  assign trig = hit | force_trig;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    fill_d  = fill_cnt;
    emit    = 1'b0;
    done_d  = 1'b0;
    if (abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      fill_d  = '0;
    end else if (arm) begin
      cnt_d  = '0;
      fill_d = '0;
      if (total_num == 32'd0) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else if (pre_num == '0) begin
        state_d = WAIT_TRIG;
      end else begin
        state_d = FILL;
      end
    end else if (proc) begin
      case (state)
        FILL: begin
          fill_d = fill_nx;
          if (fill_nx == pre_q) state_d = WAIT_TRIG;
        end
        WAIT_TRIG: begin
          if (trig) begin
            emit  = 1'b1;
            cnt_d = cnt_nx;
            if (cnt_nx == total_q) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = CAPTURE;
            end
          end
        end
        CAPTURE: begin
          emit  = 1'b1;
          cnt_d = cnt_nx;
          if (cnt_nx == total_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      fill_cnt <= '0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      fill_cnt <= fill_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= '0;
      src_q   <= 1'b0;
      lvl_q   <= '0;
      pre_q   <= '0;
      total_q <= '0;
    end else if (restart) begin
      mode_q  <= trig_mode;
      src_q   <= trig_src;
      lvl_q   <= trig_level;
      pre_q   <= pre_num;
      total_q <= total_num;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      prev_b  <= '0;
      prev_ok <= 1'b0;
    end else if (restart) begin
      wptr    <= '0;
      prev_ok <= 1'b0;
    end else if (proc) begin
      wptr    <= wptr + ADDR_W'(1);
      prev_b  <= b;
      prev_ok <= 1'b1;
    end
  end

  // read-before-write: mem[raddr] above sees the old contents this edge
  always_ff @(posedge clk) begin
    if (proc) mem[wptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      done       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      dout_valid <= emit & ~out_full;
      done       <= done_d;
      if (emit) dout <= rdata;
      if (restart) overflow <= 1'b0;
      else if (emit & out_full) overflow <= 1'b1;
    end
  end

  assign armed     = (state == FILL) | (state == WAIT_TRIG);
  assign triggered = (state == CAPTURE);

endmodule

// File: tb/tb_adc_trigger_gate.sv
// Directed bench for adc_trigger_gate: trigger modes, pre-trigger delay,
// overflow accounting, abort/arm priority and async reset.
module tb_adc_trigger_gate;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic        abort = 1'b0;
  logic [1:0]  trig_mode = '0;
  logic        trig_src = 1'b0;
  logic [7:0]  trig_level = '0;
  logic [9:0]  pre_num = '0;
  logic [31:0] total_num = '0;
  logic        force_trig = 1'b0;
  logic [15:0] din = '0;
  logic        din_valid = 1'b0;
  logic        out_full = 1'b0;
  logic [15:0] dout;
  logic        dout_valid, armed, triggered, done, overflow;

  int n_chk = 0;
  int n_err = 0;

  adc_trigger_gate #(.DATA_W(16), .ADDR_W(10)) dut (
    .clk(clk), .reset(reset), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .trig_src(trig_src),
    .trig_level(trig_level), .pre_num(pre_num),
    .total_num(total_num), .force_trig(force_trig),
    .din(din), .din_valid(din_valid), .out_full(out_full),
    .dout(dout), .dout_valid(dout_valid), .armed(armed),
    .triggered(triggered), .done(done), .overflow(overflow)
  );

  always #10 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic arm_cfg(input logic [1:0] m, input logic s,
                         input logic [7:0] l, input logic [9:0] p,
                         input logic [31:0] t);
    trig_mode = m; trig_src = s; trig_level = l;
    pre_num = p; total_num = t;
    arm = 1'b1;
    cyc();
    arm = 1'b0;
  endtask

  task automatic send(input logic [15:0] d);
    din = d;
    din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
  endtask

  int dv_cnt;
  logic [7:0] d8;
  logic [7:0] hi [5];

  initial begin
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst_dv", 32'(dout_valid), 0);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_armed", 32'(armed), 0);
    chk("rst_ovf", 32'(overflow), 0);

    // T1 immediate, no pre-trigger
    arm_cfg(2'd0, 1'b0, 8'h00, 10'd0, 32'd4);
    chk("t1_armed", 32'(armed), 1);
    for (int i = 0; i < 4; i++) begin
      send(16'(i));
      chk("t1_dv", 32'(dout_valid), 1);
      chk("t1_dout", 32'(dout), 32'(i));
      chk("t1_done", 32'(done), (i == 3) ? 1 : 0);
    end
    cyc();
    chk("t1_dv_end", 32'(dout_valid), 0);
    chk("t1_done_end", 32'(done), 0);

    // T2 rising edge with pre=3
    arm_cfg(2'd1, 1'b0, 8'h80, 10'd3, 32'd8);
    for (int i = 0; i <= 24; i++) begin
      d8 = 8'h70 + 8'(i);
      send({8'hAB, d8});
      if (d8 < 8'h80) begin
        chk("t2_dv_pre", 32'(dout_valid), 0);
        chk("t2_armed", 32'(armed), 1);
      end else if (d8 <= 8'h87) begin
        chk("t2_dv", 32'(dout_valid), 1);
        chk("t2_dout", 32'(dout), 32'({8'hAB, d8 - 8'd3}));
        chk("t2_done", 32'(done), (d8 == 8'h87) ? 1 : 0);
        chk("t2_trig", 32'(triggered), (d8 == 8'h87) ? 0 : 1);
      end else begin
        chk("t2_dv_post", 32'(dout_valid), 0);
      end
    end

    // T3 falling on high byte; first sample must not trigger
    hi[0] = 8'h40; hi[1] = 8'h60; hi[2] = 8'h58;
    hi[3] = 8'h30; hi[4] = 8'h20;
    arm_cfg(2'd2, 1'b1, 8'h50, 10'd0, 32'd2);
    for (int i = 0; i < 5; i++) begin
      send({hi[i], 8'(i)});
      chk("t3_dv", 32'(dout_valid), (i >= 3) ? 1 : 0);
      if (i >= 3) chk("t3_dout", 32'(dout), 32'({hi[i], 8'(i)}));
      chk("t3_done", 32'(done), (i == 4) ? 1 : 0);
    end

    // T4 total=0 and arm+abort
    arm_cfg(2'd0, 1'b0, 8'h00, 10'd0, 32'd0);
    chk("t4_done0", 32'(done), 1);
    chk("t4_dv0", 32'(dout_valid), 0);
    chk("t4_armed0", 32'(armed), 0);
    cyc();
    chk("t4_done_pulse", 32'(done), 0);
    abort = 1'b1;
    arm_cfg(2'd0, 1'b0, 8'h00, 10'd0, 32'd5);
    abort = 1'b0;
    chk("t4_ab_armed", 32'(armed), 0);
    chk("t4_ab_done", 32'(done), 0);
    send(16'h1234);
    chk("t4_ab_dv", 32'(dout_valid), 0);

    // T5 out_full drops two outputs but they still count
    arm_cfg(2'd0, 1'b0, 8'h00, 10'd0, 32'd6);
    dv_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      out_full = (i == 2 || i == 3);
      send(16'h0500 + 16'(i));
      out_full = 1'b0;
      if (dout_valid) dv_cnt++;
      chk("t5_done", 32'(done), (i == 5) ? 1 : 0);
    end
    chk("t5_dv_cnt", 32'(dv_cnt), 4);
    chk("t5_ovf", 32'(overflow), 1);
    cyc();
    chk("t5_ovf_sticky", 32'(overflow), 1);

    // T6 abort mid-capture, then deep pre-trigger with wrap
    arm_cfg(2'd0, 1'b0, 8'h00, 10'd0, 32'd100);
    chk("t6_ovf_clr", 32'(overflow), 0);
    for (int i = 0; i < 3; i++) send(16'(i));
    chk("t6_trig", 32'(triggered), 1);
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("t6_ab_trig", 32'(triggered), 0);
    chk("t6_ab_done", 32'(done), 0);
    chk("t6_ab_dv", 32'(dout_valid), 0);
    arm_cfg(2'd0, 1'b0, 8'h00, 10'd1023, 32'd3);
    dv_cnt = 0;
    for (int i = 0; i < 1023; i++) begin
      send(16'h1000 + 16'(i));
      if (dout_valid) dv_cnt++;
      if (i == 1021) chk("t6_fill_armed", 32'(armed), 1);
    end
    chk("t6_fill_dv", 32'(dv_cnt), 0);
    chk("t6_wait_armed", 32'(armed), 1);
    for (int i = 1023; i < 1026; i++) begin
      send(16'h1000 + 16'(i));
      chk("t6_dv", 32'(dout_valid), 1);
      chk("t6_dout", 32'(dout), 32'(16'h1000 + 16'(i - 1023)));
      chk("t6_done", 32'(done), (i == 1025) ? 1 : 0);
    end

    // T7 async reset mid-capture
    arm_cfg(2'd0, 1'b0, 8'h00, 10'd0, 32'd10);
    send(16'h7001);
    out_full = 1'b1;
    send(16'h7002);
    out_full = 1'b0;
    chk("t7_ovf", 32'(overflow), 1);
    send(16'h7003);
    chk("t7_dv", 32'(dout_valid), 1);
    chk("t7_dout", 32'(dout), 32'h7003);
    reset = 1'b1;
    #1;
    chk("t7_rst_dv", 32'(dout_valid), 0);
    chk("t7_rst_dout", 32'(dout), 0);
    chk("t7_rst_ovf", 32'(overflow), 0);
    chk("t7_rst_trig", 32'(triggered), 0);
    chk("t7_rst_armed", 32'(armed), 0);
    chk("t7_rst_done", 32'(done), 0);
    cyc();
    reset = 1'b0;
    cyc();
    chk("t7_idle", 32'(triggered), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
